// File: rtl/swi_pkg.sv
// Shared constants for the switch conditioner: bus layout, load field width
// and default debounce / auto-repeat periods.
package swi_pkg;

  localparam int NBITS_SWI        = 8;
  localparam int SWI_RESET_BIT    = 7;
  localparam int SWI_LOAD_BIT     = 6;
  localparam int LOAD_W           = 4;
  localparam int DEBOUNCE_DEFAULT = 4;
  localparam int REPEAT_DEFAULT   = 16;

  typedef logic [LOAD_W-1:0] load_val_t;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/swi_debounce_bit.sv
// One switch bit: two-flop synchronizer, run-length debounce counter,
// debounced level flop and registered rise/fall pulses.
module swi_debounce_bit
  import swi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreement restarts the qualification window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/swi_conditioner.sv
// Switch conditioner: per-bit debounce plus a load-request handshake driven by
// the load switch. Define SWI_AUTOREPEAT_EN to add periodic auto-repeat loads.
module swi_conditioner
  import swi_pkg::*;
#(
  parameter int NBITS           = NBITS_SWI,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_DEFAULT
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic [NBITS-1:0]  swi_raw,
  output logic [NBITS-1:0]  swi_stable,
  output logic [NBITS-1:0]  rise,
  output logic [NBITS-1:0]  fall,
  output logic              reset_req,
  output logic              load_valid,
  input  logic              load_ready,
  output logic [LOAD_W-1:0] load_value,
  output logic              overrun
);

  if (NBITS < NBITS_SWI || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
      REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("swi_conditioner: NBITS, DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
  end

  logic [NBITS-1:0] stable_w;
  logic [NBITS-1:0] rise_w;
  logic [NBITS-1:0] fall_w;

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    swi_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_2  (clk_2),
      .reset  (reset),
      .raw    (swi_raw[i]),
      .stable (stable_w[i]),
      .rise   (rise_w[i]),
      .fall   (fall_w[i])
    );
  end

  logic rpt_tick;

`ifdef SWI_AUTOREPEAT_EN
  localparam int               RPT_W    = cnt_width(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  // The rise cycle itself issues the first request, so counting starts on
  // the following cycle and each tick lands a whole period after the last.
  always_comb begin
    rpt_cnt_d = '0;
    rpt_tick  = 1'b0;
    if (stable_w[SWI_LOAD_BIT] && !rise_w[SWI_LOAD_BIT]) begin
      if (rpt_cnt_q == RPT_LAST) begin
        rpt_tick = !stable_w[SWI_RESET_BIT];
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_tick = 1'b0;
`endif

  logic      req;
  logic      load_valid_q, load_valid_d;
  load_val_t load_value_q, load_value_d;
  logic      overrun_q, overrun_d;

  assign req = (rise_w[SWI_LOAD_BIT] | rpt_tick) & ~stable_w[SWI_RESET_BIT];

  // Counter reset wins over everything; a new request wins over a transfer
  // so back-to-back requests are never dropped.
  always_comb begin
    load_valid_d = load_valid_q;
    load_value_d = load_value_q;
    overrun_d    = overrun_q;
    if (rise_w[SWI_RESET_BIT]) begin
      load_valid_d = 1'b0;
    end else if (req) begin
      load_valid_d = 1'b1;
      load_value_d = stable_w[LOAD_W-1:0];
      if (load_valid_q && !load_ready) begin
        overrun_d = 1'b1;
      end
    end else if (load_valid_q && load_ready) begin
      load_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      load_valid_q <= 1'b0;
      load_value_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      load_valid_q <= load_valid_d;
      load_value_q <= load_value_d;
      overrun_q    <= overrun_d;
    end
  end

  assign swi_stable = stable_w;
  assign rise       = rise_w;
  assign fall       = fall_w;
  assign reset_req  = stable_w[SWI_RESET_BIT];
  assign load_valid = load_valid_q;
  assign load_value = load_value_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_swi_conditioner.sv
// Scoreboard bench for swi_conditioner: expected edge pulses and load transfers
// are queued by the stimulus and consumed by an independent monitor.
module tb_swi_conditioner;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       load_ready = 1'b0;
  logic [7:0] swi_raw = 8'h00;
  logic [7:0] swi_stable, rise, fall;
  logic       reset_req, load_valid, overrun;
  logic [3:0] load_value;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [7:0] r;
    logic [7:0] f;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } xf_t;

  ev_t ev_q[$];
  xf_t xf_q[$];

  swi_conditioner #(
    .NBITS(8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(16)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .swi_raw    (swi_raw),
    .swi_stable (swi_stable),
    .rise       (rise),
    .fall       (fall),
    .reset_req  (reset_req),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .overrun    (overrun)
  );

  always #5 clk_2 = ~clk_2;

  always @(posedge clk_2) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic goto_neg(input int c);
    @(negedge clk_2);
    while (cyc < c) @(negedge clk_2);
  endtask

  task automatic set_raw(input logic [7:0] v, output int n);
    @(posedge clk_2);
    #1;
    swi_raw = v;
    n = cyc;
  endtask

  task automatic push_ev(input int c, input logic [7:0] r, input logic [7:0] f);
    ev_t e;
    e.cyc = c;
    e.r = r;
    e.f = f;
    ev_q.push_back(e);
  endtask

  task automatic push_xf(input int c, input logic [3:0] v);
    xf_t x;
    x.cyc = c;
    x.v = v;
    xf_q.push_back(x);
  endtask

  task automatic pulse_ready(input logic [3:0] v);
    @(posedge clk_2);
    #1;
    load_ready = 1'b1;
    push_xf(cyc, v);
    @(posedge clk_2);
    #1;
    load_ready = 1'b0;
  endtask

  // Monitor: every edge pulse and every completed transfer must match the
  // oldest outstanding expectation.
  always @(negedge clk_2) begin : mon
    ev_t e;
    xf_t x;
    if (!reset) begin
      if ((rise | fall) != 8'h00) begin
        checks++;
        if (ev_q.size() == 0) begin
          failures++;
          $display("FAIL edge_unexpected cyc=%0d actual rise=%h fall=%h required none",
                   cyc, rise, fall);
        end else begin
          e = ev_q.pop_front();
          if (cyc != e.cyc || rise !== e.r || fall !== e.f) begin
            failures++;
            $display("FAIL edge actual cyc=%0d rise=%h fall=%h required cyc=%0d rise=%h fall=%h",
                     cyc, rise, fall, e.cyc, e.r, e.f);
          end
        end
      end
      if (load_valid && load_ready) begin
        checks++;
        if (xf_q.size() == 0) begin
          failures++;
          $display("FAIL xfer_unexpected cyc=%0d actual value=%h required none",
                   cyc, load_value);
        end else begin
          x = xf_q.pop_front();
          if (cyc != x.cyc || load_value !== x.v) begin
            failures++;
            $display("FAIL xfer actual cyc=%0d value=%h required cyc=%0d value=%h",
                     cyc, load_value, x.cyc, x.v);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int n2;

    repeat (3) @(posedge clk_2);
    @(negedge clk_2);
    chk("rst_stable", swi_stable, 8'h00);
    chk("rst_edges", {rise, fall}, 16'h0000);
    chk("rst_handshake", {reset_req, load_valid, overrun, load_value}, 7'h00);
    @(posedge clk_2);
    #1 reset = 1'b0;

    // Sustained change on bit 2: six cycles to the new level
    set_raw(8'h04, n);
    push_ev(n + 6, 8'h04, 8'h00);
    goto_neg(n + 5);
    chk("latency_before", swi_stable, 8'h00);
    goto_neg(n + 6);
    chk("latency_at", swi_stable, 8'h04);
    chk("rise2_pulse", rise, 8'h04);
    goto_neg(n + 7);
    chk("rise2_width", rise, 8'h00);
    set_raw(8'h00, n);
    push_ev(n + 6, 8'h00, 8'h04);
    goto_neg(n + 8);

    // Three-cycle glitch is rejected
    set_raw(8'h04, n);
    repeat (2) @(posedge clk_2);
    set_raw(8'h00, n2);
    goto_neg(n + 12);
    chk("glitch_stable", swi_stable, 8'h00);

    // Load request with A, held while not ready, then one transfer
    set_raw(8'h0A, n);
    push_ev(n + 6, 8'h0A, 8'h00);
    goto_neg(n + 8);
    set_raw(8'h4A, n);
    push_ev(n + 6, 8'h40, 8'h00);
    goto_neg(n + 7);
    chk("req_valid", load_valid, 1'b1);
    chk("req_value", load_value, 4'hA);
    goto_neg(n + 13);
    set_raw(8'h0A, n2);
    push_ev(n2 + 6, 8'h00, 8'h40);
    goto_neg(n + 16);
    chk("hold_valid", load_valid, 1'b1);
    chk("hold_value", load_value, 4'hA);
    pulse_ready(4'hA);
    goto_neg(n + 18);
    chk("xfer_clears", load_valid, 1'b0);
    chk("no_overrun", overrun, 1'b0);
    goto_neg(n + 22);

    // Pending A overwritten by 5 while not ready: overrun
    set_raw(8'h4A, n);
    push_ev(n + 6, 8'h40, 8'h00);
    goto_neg(n + 7);
    chk("pend_value", {load_valid, overrun, load_value}, 6'b10_1010);
    set_raw(8'h05, n2);
    push_ev(n2 + 6, 8'h05, 8'h4A);
    goto_neg(n2 + 8);
    set_raw(8'h45, n);
    push_ev(n + 6, 8'h40, 8'h00);
    goto_neg(n + 7);
    chk("latest_value", load_value, 4'h5);
    chk("overrun_set", overrun, 1'b1);
    pulse_ready(4'h5);
    goto_neg(n + 9);
    chk("overrun_sticky", {load_valid, overrun}, 2'b01);

    // Counter reset request clears a pending load and blocks new ones
    set_raw(8'h05, n2);
    push_ev(n2 + 6, 8'h00, 8'h40);
    goto_neg(n2 + 8);
    set_raw(8'h45, n);
    push_ev(n + 6, 8'h40, 8'h00);
    goto_neg(n + 7);
    chk("pend2_valid", {load_valid, load_value}, 5'h15);
    set_raw(8'hC5, n2);
    push_ev(n2 + 6, 8'h80, 8'h00);
    goto_neg(n2 + 6);
    chk("reset_req_on", {reset_req, load_valid}, 2'b11);
    goto_neg(n2 + 7);
    chk("rstreq_clears_valid", load_valid, 1'b0);
    set_raw(8'h85, n);
    push_ev(n + 6, 8'h00, 8'h40);
    goto_neg(n + 8);
    set_raw(8'hC5, n);
    push_ev(n + 6, 8'h40, 8'h00);
    goto_neg(n + 12);
    chk("rise6_ignored", load_valid, 1'b0);

    // Reset while bits 6 and 7 are mid-debounce
    set_raw(8'h05, n);
    repeat (2) @(posedge clk_2);
    @(posedge clk_2);
    #1;
    reset = 1'b1;
    swi_raw = 8'h00;
    goto_neg(n + 4);
    chk("midrst_stable", swi_stable, 8'h00);
    chk("midrst_edges", {rise, fall}, 16'h0000);
    chk("midrst_outputs", {reset_req, load_valid, overrun, load_value}, 7'h00);
    @(posedge clk_2);
    #1;
    reset = 1'b0;
    load_ready = 1'b1;

    // Load switch held 40 cycles with the consumer always ready
    set_raw(8'h43, n);
    push_ev(n + 6, 8'h43, 8'h00);
    push_xf(n + 7, 4'h3);
`ifdef SWI_AUTOREPEAT_EN
    push_xf(n + 23, 4'h3);
    push_xf(n + 39, 4'h3);
`endif
    goto_neg(n + 8);
    chk("t0_single_cycle", load_valid, 1'b0);
    goto_neg(n + 40);
    set_raw(8'h00, n2);
    push_ev(n2 + 6, 8'h00, 8'h43);
    goto_neg(n2 + 10);
    chk("repeat_no_overrun", overrun, 1'b0);
    chk("edges_all_seen", ev_q.size(), 0);
    chk("xfers_all_seen", xf_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swi_conditioner.md
SWI_CONDITIONER -- requirements
Module: swi_conditioner

Interface
REQ-001 SHALL have parameter NBITS, default 8, meaning switch bus width.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive synchronized cycles required to accept a new level (legal range 2..255).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 16, meaning auto-repeat period in cycles; it is ignored when the repeat feature (REQ-025) is compiled out.
REQ-004 SHALL have port clk_2, input, 1 bit: clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port swi_raw, input, NBITS: asynchronous switch levels.
REQ-007 SHALL have port swi_stable, output, NBITS: debounced levels.
REQ-008 SHALL have ports rise and fall, output, NBITS each: one-cycle edge pulses per bit.
REQ-009 SHALL have port reset_req, output, 1 bit: equals swi_stable[7] and feeds the counter's reset.
REQ-010 SHALL have ports load_valid (output, 1), load_ready (input, 1) and load_value (output, 4): load request handshake.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag for a lost load request.

Function
REQ-012 SHALL pass each swi_raw bit through a two-flop synchronizer; s[i] is the raw value delayed 2 cycles.
REQ-013 SHALL, per bit, increment cnt[i] while s[i]!=swi_stable[i] and clear cnt[i] when they are equal.
REQ-014 SHALL, when s[i]!=swi_stable[i] and cnt[i]==DEBOUNCE_CYCLES-1, update swi_stable[i]<=s[i] and clear cnt[i].
REQ-015 SHALL produce a total latency of exactly 2+DEBOUNCE_CYCLES cycles from a sustained raw change to the swi_stable change.
REQ-016 SHALL reject any glitch shorter than DEBOUNCE_CYCLES synchronized cycles with no output effect.
REQ-017 SHALL assert rise[i] (fall[i]) for exactly the one cycle in which swi_stable[i] first reads 1 (0); edge pulses are registered.
REQ-018 SHALL, on rise[6] while swi_stable[7]==0, set load_valid=1 and capture load_value=swi_stable[3:0] on the same edge.
REQ-019 SHALL hold load_valid and load_value stable until load_valid&&load_ready; a transfer clears load_valid on the next cycle.
REQ-020 SHALL, when a new request and a transfer coincide, keep load_valid=1 and present the new load_value.
REQ-021 SHALL, on a new request while load_valid=1 and load_ready=0, overwrite load_value (latest wins) and set overrun=1 until reset.
REQ-022 SHALL clear a pending load_valid on rise[7], and ignore rise[6] while swi_stable[7]==1.
REQ-023 SHALL treat load_ready as don't-care while load_valid=0.

Reset
REQ-024 SHALL, on reset, clear synchronizer flops, cnt, swi_stable, rise, fall, load_valid, load_value, overrun and the repeat counter on the next edge; reset takes effect mid-debounce and mid-handshake, and all outputs read 0 in the cycle after reset.

Configuration
REQ-025 SHALL, with SWI_AUTOREPEAT_EN defined, issue an additional load request (per REQ-018..021) every REPEAT_CYCLES cycles while swi_stable[6]==1 and swi_stable[7]==0, counted from rise[6], with the repeat counter clearing when swi_stable[6]==0.
REQ-026 SHALL, without SWI_AUTOREPEAT_EN, generate load requests only on rise[6], with no repeat counter present.

Structure
REQ-027 SHALL take from shared package swi_pkg: NBITS_SWI=8, SWI_RESET_BIT=7, SWI_LOAD_BIT=6, LOAD_W=4, DEBOUNCE_DEFAULT=4 and REPEAT_DEFAULT=16.
REQ-028 SHALL use one sub-module, swi_debounce_bit (synchronizer, counter, stable flop, edge pulses), instantiated NBITS times; handshake and repeat logic stay in the top.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 SHALL cover: swi_raw[2] 0->1 held -> swi_stable[2]=1 and rise[2] one-cycle pulse exactly 6 cycles after the change.
REQ-030 SHALL cover: swi_raw[2] high for 3 cycles then low -> swi_stable[2] stays 0 and rise[2] never pulses.
REQ-031 SHALL cover: swi_raw[3:0]=4'hA, swi_raw[6] raised, load_ready=0 -> load_valid=1 and load_value=A held for 10 cycles; then load_ready=1 for one cycle -> load_valid=0 on the next cycle and overrun=0.
REQ-032 SHALL cover: A pending with load_ready=0, then swi_raw[6] dropped and re-raised with swi_raw[3:0]=5 -> load_value=5 and overrun=1 until reset.
REQ-033 SHALL cover: swi_raw[7] raised with a load pending -> reset_req=1, load_valid=0 and a subsequent swi_raw[6] edge is ignored; reset asserted mid-debounce -> all outputs 0 the next cycle.
REQ-034 SHALL cover, with SWI_AUTOREPEAT_EN and REPEAT_CYCLES=16: swi_raw[6] held 40 cycles with load_ready=1 -> load_valid pulses at t0, t0+16 and t0+32; without the macro -> only the pulse at t0.
